alu_share_arb: RTL and testbench

Round-robin arbiter and sequencer sharing one combinational `alu_16bit_extended` among `NUM_REQ` requesters. It registers the winning request's operands and opcode onto the ALU inputs and holds them for `WAIT_CYC` cycles, so slow ops (div, mod, GCD, LCM, power, trig) meet timing as multicycle paths. It then captures `result`/`carry_out` and returns them to the owning requester with a one-cycle response pulse. It sits between the instruction-issue ports and the single shared ALU instance.

---
 rtl/alu_arb_pkg.sv | 17 +
 rtl/alu_rr_grant.sv | 33 +++
 rtl/alu_share_arb.sv | 158 +++++++++++++++
 tb/tb_alu_share_arb.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the round-robin ALU sharing arbiter.
// Optional div/mod-by-zero trapping is enabled with ALU_ARB_DIV0_TRAP_EN.
package alu_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } arb_state_t;

  localparam logic [7:0] OP_DIV = 8'h03;
  localparam logic [7:0] OP_MOD = 8'h04;

  localparam int unsigned DEF_WAIT_CYC = 2;
  // Hold counter wide enough for WAIT_CYC up to 15.
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/alu_rr_grant.sv
// Combinational round-robin grant: search starts one past the last winner.
module alu_rr_grant
  import alu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       any
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0] w_idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    w_idx    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = ID_W'((32'(last_grant) + k) % NUM_REQ);
      if (!any && req[w_idx]) begin
        any          = 1'b1;
        grant_id     = w_idx;
        grant[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Arbitrates NUM_REQ requesters onto one shared combinational ALU, holding its
// inputs WAIT_CYC cycles before capture. Define ALU_ARB_DIV0_TRAP_EN to trap div/mod by zero.
module alu_share_arb
  import alu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned OP_W     = 8,
  parameter int unsigned WAIT_CYC = DEF_WAIT_CYC
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_carry,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [DATA_W-1:0]         alu_operand_a,
  output logic [DATA_W-1:0]         alu_operand_b,
  output logic [OP_W-1:0]           alu_operation,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic                      alu_carry_out
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  arb_state_t          r_state, w_state_nxt;
  logic [ID_W-1:0]     r_last_grant, r_id;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_alu_a, r_alu_b, r_rsp_result;
  logic [OP_W-1:0]     r_alu_op;
  logic [NUM_REQ-1:0]  r_rsp_valid;
  logic                r_rsp_carry;

  logic [NUM_REQ-1:0]  w_grant;
  logic [ID_W-1:0]     w_grant_id;
  logic                w_any, w_accept, w_done, w_trap, w_trap_pend;
  logic [DATA_W-1:0]   w_sel_a, w_sel_b;
  logic [OP_W-1:0]     w_sel_op;

  alu_rr_grant #(.NUM_REQ(NUM_REQ)) u_grant (
    .req        (req_valid),
    .last_grant (r_last_grant),
    .grant      (w_grant),
    .grant_id   (w_grant_id),
    .any        (w_any)
  );

  assign w_accept  = w_any && (r_state == IDLE) && !rst;
  assign req_ready = w_accept ? w_grant : '0;

  // Payload mux for the winning requester.
  always_comb begin
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_a  = req_a[i*DATA_W +: DATA_W];
        w_sel_b  = req_b[i*DATA_W +: DATA_W];
        w_sel_op = req_op[i*OP_W +: OP_W];
      end
    end
  end

`ifdef ALU_ARB_DIV0_TRAP_EN
  logic r_trap_pend, r_rsp_err;

  assign w_trap = w_accept && (w_sel_b == '0) &&
                  ((w_sel_op == OP_W'(OP_DIV)) || (w_sel_op == OP_W'(OP_MOD)));
  assign w_trap_pend = r_trap_pend;
  assign rsp_err     = r_rsp_err;

  // Trapped requests answer one edge after accept without touching the ALU.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_trap_pend <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_trap_pend <= w_trap;
      if (r_trap_pend) r_rsp_err <= 1'b1;
      else if (w_done) r_rsp_err <= 1'b0;
    end
  end
`else
  assign w_trap      = 1'b0;
  assign w_trap_pend = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    case (r_state)
      IDLE: if (w_accept && !w_trap) w_state_nxt = EXEC;
      EXEC: begin
        if (r_cnt == CNT_W'(WAIT_CYC - 1)) begin
          w_state_nxt = IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= ID_W'(NUM_REQ - 1);
      r_id         <= '0;
      r_cnt        <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= '0;
      r_rsp_valid  <= '0;
      r_rsp_result <= '0;
      r_rsp_carry  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rsp_valid <= '0;
      if (w_accept) begin
        r_last_grant <= w_grant_id;
        r_id         <= w_grant_id;
        r_cnt        <= '0;
        if (!w_trap) begin
          r_alu_a  <= w_sel_a;
          r_alu_b  <= w_sel_b;
          r_alu_op <= w_sel_op;
        end
      end else if (r_state == EXEC) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_done) begin
        r_rsp_valid  <= NUM_REQ'(1) << r_id;
        r_rsp_result <= alu_result;
        r_rsp_carry  <= alu_carry_out;
      end else if (w_trap_pend) begin
        r_rsp_valid  <= NUM_REQ'(1) << r_id;
        r_rsp_result <= '1;
        r_rsp_carry  <= 1'b0;
      end
    end
  end

  assign busy          = (r_state == EXEC);
  assign rsp_valid     = r_rsp_valid;
  assign rsp_result    = r_rsp_result;
  assign rsp_carry     = r_rsp_carry;
  assign alu_operand_a = r_alu_a;
  assign alu_operand_b = r_alu_b;
  assign alu_operation = r_alu_op;

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb with a timeline-based reference model
// and a small ALU stand-in; honours ALU_ARB_DIV0_TRAP_EN when defined.
module tb_alu_share_arb;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned OW = 8;
  localparam int unsigned W  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid, req_ready, rsp_valid;
  logic [N*DW-1:0]   req_a, req_b;
  logic [N*OW-1:0]   req_op;
  logic [DW-1:0]     rsp_result, alu_operand_a, alu_operand_b, alu_result;
  logic              rsp_carry, rsp_err, busy, alu_carry_out;
  logic [OW-1:0]     alu_operation;

  always #5 clk = ~clk;

  alu_share_arb #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW), .WAIT_CYC(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_carry(rsp_carry),
    .rsp_err(rsp_err), .busy(busy),
    .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
    .alu_operation(alu_operation),
    .alu_result(alu_result), .alu_carry_out(alu_carry_out)
  );

  // ALU stand-in: returns {carry, result}.
  function automatic logic [DW:0] alu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [OW-1:0] op);
    logic [2*DW-1:0] p;
    case (op)
      8'h00: return {1'b0, a} + {1'b0, b};
      8'h01: return {1'b0, a} - {1'b0, b};
      8'h02: begin
        p = {16'h0, a} * {16'h0, b};
        return {|p[2*DW-1:DW], p[DW-1:0]};
      end
      8'h03: return (b == 0) ? {1'b1, 16'h0000} : {1'b0, a / b};
      8'h04: return (b == 0) ? {1'b0, a} : {1'b0, a % b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  always_comb {alu_carry_out, alu_result} = alu_ref(alu_operand_a, alu_operand_b, alu_operation);

  typedef struct {
    int unsigned   due;
    int            id;
    logic [DW-1:0] res;
    logic          c;
    logic          err;
  } rsp_t;

  int total = 0, bad = 0;
  int unsigned e = 0, free_at = 0;
  int m_last = N - 1;
  logic [DW-1:0] m_a = '0, m_b = '0, m_res = '0;
  logic [OW-1:0] m_op = '0;
  logic [N-1:0]  m_rv = '0;
  logic          m_c = 1'b0, m_err = 1'b0;
  rsp_t pend[$];

  logic [N-1:0]  v;
  logic [DW-1:0] ra[N], rb[N];
  logic [OW-1:0] rop[N];

  int          acc_id[$];
  int unsigned acc_e[$];
  logic        b2b_seen = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [OW-1:0] op);
    v[i] = 1'b1; ra[i] = a; rb[i] = b; rop[i] = op;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]        = v[i];
      req_a[i*DW +: DW]   = ra[i];
      req_b[i*DW +: DW]   = rb[i];
      req_op[i*OW +: OW]  = rop[i];
    end
  endtask

  // Expected winner this cycle, -1 when nothing may be accepted.
  function automatic int exp_grant();
    if (rst || (e + 1 < free_at)) return -1;
    for (int k = 1; k <= N; k++) begin
      if (v[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_last = N - 1; m_a = '0; m_b = '0; m_op = '0;
    m_rv = '0; m_res = '0; m_c = 1'b0; m_err = 1'b0;
    pend.delete(); free_at = 0;
  endtask

  task automatic model_accept(input int g);
    logic trap;
    logic [DW:0] r;
    rsp_t x;
    trap = 1'b0;
`ifdef ALU_ARB_DIV0_TRAP_EN
    trap = ((rop[g] == 8'h03) || (rop[g] == 8'h04)) && (rb[g] == 0);
`endif
    x.id = g;
    if (trap) begin
      x.due = e + 1; x.res = '1; x.c = 1'b0; x.err = 1'b1;
    end else begin
      m_a = ra[g]; m_b = rb[g]; m_op = rop[g];
      r = alu_ref(ra[g], rb[g], rop[g]);
      x.due = e + W; x.res = r[DW-1:0]; x.c = r[DW]; x.err = 1'b0;
      free_at = e + W + 1;
    end
    pend.push_back(x);
    m_last = g;
  endtask

  task automatic tick();
    int g;
    rsp_t x;
    drive();
    @(negedge clk);
    g = exp_grant();
    chk("req_ready", 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
    chk("busy", 64'(busy), 64'(e + 1 < free_at));
    chk("rsp_valid", 64'(rsp_valid), 64'(m_rv));
    chk("rsp_result", 64'(rsp_result), 64'(m_res));
    chk("rsp_carry", 64'(rsp_carry), 64'(m_c));
    chk("rsp_err", 64'(rsp_err), 64'(m_err));
    chk("alu_a", 64'(alu_operand_a), 64'(m_a));
    chk("alu_b", 64'(alu_operand_b), 64'(m_b));
    chk("alu_op", 64'(alu_operation), 64'(m_op));
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        acc_id.push_back(i);
        acc_e.push_back(e + 1);
      end
    end
    if (rsp_valid[0] && req_valid[0] && req_ready[0]) b2b_seen = 1'b1;
    @(posedge clk);
    e++;
    if (rst) begin
      model_reset();
    end else begin
      if (g >= 0) begin
        model_accept(g);
        v[g] = 1'b0;
      end
      m_rv = '0;
      while (pend.size() > 0 && pend[0].due == e) begin
        x = pend.pop_front();
        m_rv[x.id] = 1'b1; m_res = x.res; m_c = x.c; m_err = x.err;
      end
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int s;
    logic [DW:0] r4;
    v = '0;
    for (int i = 0; i < N; i++) begin ra[i] = '0; rb[i] = '0; rop[i] = '0; end
    rst = 1'b1;
    drive();
    @(posedge clk); #1;
    // Reset state, with a request present to confirm ready stays low in reset.
    set_req(0, 16'd1, 16'd2, 8'h00);
    tick();
    v = '0;
    rst = 1'b0;
    run(2);

    // Single add request.
    set_req(0, 16'd100, 16'd200, 8'h00);
    run(W + 2);
    chk("t1_result", 64'(rsp_result), 64'd300);
    chk("t1_carry", 64'(rsp_carry), 64'd0);

    // All four requesting 12x12 from reset; requester 0 re-requests after its grant.
    for (int i = 0; i < N; i++) set_req(i, 16'd12, 16'd12, 8'h02);
    rst = 1'b1; tick(); rst = 1'b0;
    s = acc_id.size();
    tick();
    set_req(0, 16'd12, 16'd12, 8'h02);
    run(4 * (W + 1) + W + 1);
    for (int k = 0; k < 5; k++) begin
      if (s + k < acc_id.size()) chk("t2_order", 64'(acc_id[s+k]), 64'(k % N));
      else chk("t2_missing_accept", 64'(acc_id.size()), 64'(s + 5));
    end
    for (int k = 1; k < 5; k++) begin
      if (s + k < acc_e.size()) chk("t2_spacing", 64'(acc_e[s+k] - acc_e[s+k-1]), 64'(W + 1));
    end
    chk("t2_result", 64'(rsp_result), 64'd144);

    // Priority after requester 1 was last granted.
    set_req(1, 16'd5, 16'd3, 8'h01);
    run(W + 2);
    s = acc_id.size();
    set_req(1, 16'd9, 16'd4, 8'h01);
    set_req(2, 16'd7, 16'd7, 8'h00);
    run(2 * (W + 1) + 2);
    if (s + 1 < acc_id.size()) begin
      chk("t3_first", 64'(acc_id[s]), 64'd2);
      chk("t3_second", 64'(acc_id[s+1]), 64'd1);
    end else chk("t3_missing_accept", 64'(acc_id.size()), 64'(s + 2));

    // Divide by zero on requester 3.
    set_req(3, 16'd100, 16'd0, 8'h03);
    run(W + 3);
    r4 = alu_ref(16'd100, 16'd0, 8'h03);
`ifdef ALU_ARB_DIV0_TRAP_EN
    chk("t4_result", 64'(rsp_result), 64'hFFFF);
    chk("t4_err", 64'(rsp_err), 64'd1);
`else
    chk("t4_result", 64'(rsp_result), 64'(r4[DW-1:0]));
    chk("t4_err", 64'(rsp_err), 64'd0);
`endif

    // Reset one cycle after accepting a GCD-style op.
    set_req(0, 16'd36, 16'd60, 8'h26);
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_alu_a", 64'(alu_operand_a), 64'd0);
    s = acc_id.size();
    set_req(0, 16'd1, 16'd1, 8'h00);
    set_req(1, 16'd2, 16'd2, 8'h00);
    run(2 * (W + 1) + 2);
    if (s < acc_id.size()) chk("t5_next_grant", 64'(acc_id[s]), 64'd0);
    else chk("t5_missing_accept", 64'(acc_id.size()), 64'(s + 1));

    // Back-to-back on requester 0.
    b2b_seen = 1'b0;
    s = acc_id.size();
    set_req(0, 16'd5, 16'd6, 8'h00);
    tick();
    set_req(0, 16'd7, 16'd8, 8'h01);
    run(2 * (W + 1) + 1);
    chk("t6_b2b", 64'(b2b_seen), 64'd1);
    if (s + 1 < acc_e.size()) chk("t6_spacing", 64'(acc_e[s+1] - acc_e[s]), 64'(W + 1));
    else chk("t6_missing_accept", 64'(acc_e.size()), 64'(s + 2));

    // Randomised traffic with occasional drops and resets.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i]) begin
          if ($urandom % 3 == 0) begin
            logic [OW-1:0] op;
            case ($urandom % 6)
              0: op = 8'h00; 1: op = 8'h01; 2: op = 8'h02;
              3: op = 8'h03; 4: op = 8'h04; default: op = 8'h26;
            endcase
            set_req(i, DW'($urandom), ($urandom % 4 == 0) ? '0 : DW'($urandom), op);
          end
        end else if ($urandom % 20 == 0) begin
          v[i] = 1'b0;
        end
      end
      rst = ($urandom % 97 == 0);
      tick();
    end
    rst = 1'b0;
    v = '0;
    run(W + 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
